pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Pipeline hazard and stall scheduler for the 5-stage ARM32 pipeline. Each cycle it decides whether the fetch, decode, execute and memory pipeline units advance, hold, or are squashed. It drives their `sel_stall` and `branch_in` (flush) controls from three conditions:
- load-use hazards between decode and execute;
- taken branches resolved in execute;
- data-memory wait.

It sits beside the stage controllers and is the single owner of every stall and flush line.

## Interface
Parameters:
- `LOAD_STALL_CYCLES`, default 1: bubbles inserted per load-use hazard. Legal range 1..15.
- `FLUSH_CYCLES`, default 2: cycles fetch/decode are squashed after a taken branch. Legal range 1..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `dec_valid` in 1: decode holds a real instruction (not NOP `7'b0100000`).
- `dec_rn`, `dec_rm`, `dec_rs` in 4 each: decode source registers.
- `dec_use_rn`, `dec_use_rm`, `dec_use_rs` in 1 each: the matching source is actually read.
- `ex_is_load` in 1: execute holds an LDR (any form).
- `ex_rd` in 4: LDR destination register in execute.
- `br_taken` in 1: execute resolved a taken branch or BX this cycle.
- `mem_busy` in 1: data memory not ready; the whole pipe must freeze.
- `stall_fetch`, `stall_decode`, `stall_execute`, `stall_memory` out 1 each: hold the stage register. These drive `sel_stall`.
- `bubble_execute` out 1: load NOP into execute next edge.
- `flush_fetch`, `flush_decode` out 1 each: squash the stage to NOP. These drive `branch_in`.
- `state` out 2: FSM state, for debug.
- `stall_cycles` out 16: saturating count of cycles with any stall or flush output high.

## Operation
- FSM states:
  - `RUN` = 0
  - `LOAD_STALL` = 1
  - `FLUSH` = 2
  - Encoding 3 is unused and recovers to `RUN` on the next edge.
- Hazard definition: `hazard = dec_valid & ex_is_load & ((dec_use_rn & dec_rn==ex_rd) | (dec_use_rm & dec_rm==ex_rd) | (dec_use_rs & dec_rs==ex_rd))`.
- Priority, highest first:
  1. `rst_n` low
  2. `mem_busy`
  3. `br_taken`
  4. `hazard`
- `mem_busy` = 1, in any state:
  - All four `stall_*` = 1; bubble and flush outputs = 0.
  - State and counter freeze.
- `RUN`, `br_taken` = 1:
  - `flush_fetch` = `flush_decode` = 1 this cycle.
  - If `FLUSH_CYCLES` > 1, go to `FLUSH` with `cnt` = `FLUSH_CYCLES`-1.
  - Any load-use hazard in this cycle is ignored.
- `RUN`, `hazard` = 1 (no branch):
  - `stall_fetch` = `stall_decode` = `bubble_execute` = 1 this cycle.
  - If `LOAD_STALL_CYCLES` > 1, go to `LOAD_STALL` with `cnt` = `LOAD_STALL_CYCLES`-1.
- `LOAD_STALL`:
  - Outputs are the same as the `RUN` hazard case.
  - `cnt` decrements each non-frozen cycle; at `cnt`==1 go to `RUN` on that edge.
  - Hazard is not re-evaluated while here.
  - `br_taken` cannot occur here, because execute holds a bubble. If it is asserted anyway, it is honoured as in `RUN` and takes precedence.
- `FLUSH`:
  - `flush_fetch` = `flush_decode` = 1; `hazard` is ignored.
  - `cnt` decrements, exit as in `LOAD_STALL`.
  - A new `br_taken` here reloads `cnt` = `FLUSH_CYCLES`-1.
- Load to R15 (`ex_rd`==15) needs no special case; execute reports it through `br_taken`.
- `stall_cycles`: +1 on each edge where any `stall_*`, `bubble_execute` or `flush_*` output is high. It saturates at `16'hFFFF`.

## Timing
- Stall, bubble and flush outputs are combinational from the current state and inputs (Mealy), so they act on the same edge that would otherwise advance the pipe.
- `state`, `cnt` and `stall_cycles` are registered.
- Latency:
  - A hazard costs exactly `LOAD_STALL_CYCLES` cycles with `stall_decode` high.
  - A branch costs exactly `FLUSH_CYCLES` cycles with flush high.
  - Each adds 1 cycle per `mem_busy` cycle during the sequence.
- Reset: any edge with `rst_n` = 0 gives `state` = `RUN`, `cnt` = 0, `stall_cycles` = 0.
  - All combinational outputs are forced to 0 while `rst_n` is low.
  - This applies mid-sequence: an abandoned stall or flush is not resumed.
- Simultaneous `br_taken` and `hazard`: the flush wins, with no stall.
- Simultaneous `mem_busy` and `br_taken`: freeze. The branch is re-presented next cycle because execute held.

## Structure
- Shared package `pipeline_ctrl_pkg` holds:
  - the `hz_state_t` enum (`RUN`/`LOAD_STALL`/`FLUSH`);
  - `OPCODE_NOP` = `7'b0100000`;
  - the `CNT_W` = 4 constant.
- One sub-module, `hazard_detect`: purely combinational register comparator that produces `hazard`.
- FSM, counter and perf counter live in the top module.

## Test plan
- LDR R3 in execute, decode ADD reads R3 via rm, `LOAD_STALL_CYCLES`=1 -> exactly 1 cycle of `stall_fetch`/`stall_decode`/`bubble_execute`, `state` stays 0, `stall_cycles`=1.
- Same stimulus with `LOAD_STALL_CYCLES`=3 and `mem_busy` high for 2 cycles in the middle -> 5 cycles of `stall_decode`, all four `stall_*` high during the 2 busy cycles, return to `RUN`.
- `br_taken` pulse, `FLUSH_CYCLES`=2 -> `flush_fetch`/`flush_decode` high 2 cycles, `state` 0->2->0; a coincident hazard produces no `bubble_execute`.
- `br_taken` on the second `FLUSH` cycle -> flush extended to 3 cycles total.
- `rst_n` low during `LOAD_STALL` (`cnt`=2) -> next edge: all outputs 0, `state`=0, `stall_cycles`=0.
- Hazard with `dec_use_rm`=0 but `dec_rm`==`ex_rd`, or with `dec_valid`=0 -> no stall; preloaded `stall_cycles`=`16'hFFFF` stays `16'hFFFF` after a further stall.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall scheduler.
//   hz_state_t : scheduler FSM state (encoding 3 unused, recovers to RUN)
//   OPCODE_NOP : opcode pattern decode reports as "not a real instruction"
//   CNT_W      : width of the stall/flush sequence counter
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2
  } hz_state_t;

  localparam logic [6:0] OPCODE_NOP = 7'b0100000;
  localparam int unsigned CNT_W     = 4;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator.
// Ports:
//   dec_valid               in  : decode holds a real instruction
//   dec_rn/rm/rs            in  : decode source register numbers
//   dec_use_rn/rm/rs        in  : matching source is actually read
//   ex_is_load              in  : execute holds an LDR
//   ex_rd                   in  : LDR destination in execute
//   hazard                  out : decode needs the load result not yet available
module hazard_detect (
  input  logic       dec_valid,
  input  logic [3:0] dec_rn,
  input  logic [3:0] dec_rm,
  input  logic [3:0] dec_rs,
  input  logic       dec_use_rn,
  input  logic       dec_use_rm,
  input  logic       dec_use_rs,
  input  logic       ex_is_load,
  input  logic [3:0] ex_rd,
  output logic       hazard
);

  logic match_rn, match_rm, match_rs;

  always_comb begin
    match_rn = dec_use_rn & (dec_rn == ex_rd);
    match_rm = dec_use_rm & (dec_rm == ex_rd);
    match_rs = dec_use_rs & (dec_rs == ex_rd);
    hazard   = dec_valid & ex_is_load & (match_rn | match_rm | match_rs);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard and stall scheduler: sole owner of every stall and flush line.
// Ports:
//   clk, rst_n                     : clock, synchronous active-low reset
//   dec_* / ex_is_load / ex_rd     : load-use hazard operands
//   br_taken                       : taken branch/BX resolved in execute
//   mem_busy                       : data memory not ready, freeze everything
//   stall_fetch..stall_memory      : hold stage registers (sel_stall)
//   bubble_execute                 : load NOP into execute next edge
//   flush_fetch, flush_decode      : squash stage to NOP (branch_in)
//   state                          : FSM state (debug)
//   stall_cycles                   : saturating count of cycles with any control high
// Control outputs are Mealy so they act on the edge that would otherwise advance the pipe.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_valid,
  input  logic [3:0]  dec_rn,
  input  logic [3:0]  dec_rm,
  input  logic [3:0]  dec_rs,
  input  logic        dec_use_rn,
  input  logic        dec_use_rm,
  input  logic        dec_use_rs,
  input  logic        ex_is_load,
  input  logic [3:0]  ex_rd,
  input  logic        br_taken,
  input  logic        mem_busy,
  output logic        stall_fetch,
  output logic        stall_decode,
  output logic        stall_execute,
  output logic        stall_memory,
  output logic        bubble_execute,
  output logic        flush_fetch,
  output logic        flush_decode,
  output logic [1:0]  state,
  output logic [15:0] stall_cycles
);

  localparam logic [CNT_W-1:0] LoadReload  = CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] FlushReload = CNT_W'(FLUSH_CYCLES - 1);

  hz_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      stall_cycles_q, stall_cycles_d;
  logic             hazard;
  logic             any_ctrl;

  hazard_detect u_hazard_detect (
    .dec_valid  (dec_valid),
    .dec_rn     (dec_rn),
    .dec_rm     (dec_rm),
    .dec_rs     (dec_rs),
    .dec_use_rn (dec_use_rn),
    .dec_use_rm (dec_use_rm),
    .dec_use_rs (dec_use_rs),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .hazard     (hazard)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    stall_fetch    = 1'b0;
    stall_decode   = 1'b0;
    stall_execute  = 1'b0;
    stall_memory   = 1'b0;
    bubble_execute = 1'b0;
    flush_fetch    = 1'b0;
    flush_decode   = 1'b0;

    if (!rst_n) begin
      // Outputs stay low; the register block performs the actual reset.
    end else if (mem_busy) begin
      stall_fetch   = 1'b1;
      stall_decode  = 1'b1;
      stall_execute = 1'b1;
      stall_memory  = 1'b1;
    end else begin
      case (state_q)
        RUN, LOAD_STALL, FLUSH: begin
          if (br_taken) begin
            // Branch outranks any hazard and (re)starts the flush sequence.
            flush_fetch  = 1'b1;
            flush_decode = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = FLUSH;
              cnt_d   = FlushReload;
            end else begin
              state_d = RUN;
              cnt_d   = '0;
            end
          end else if (state_q == RUN) begin
            if (hazard) begin
              stall_fetch    = 1'b1;
              stall_decode   = 1'b1;
              bubble_execute = 1'b1;
              if (LOAD_STALL_CYCLES > 1) begin
                state_d = LOAD_STALL;
                cnt_d   = LoadReload;
              end
            end
          end else begin
            if (state_q == LOAD_STALL) begin
              stall_fetch    = 1'b1;
              stall_decode   = 1'b1;
              bubble_execute = 1'b1;
            end else begin
              flush_fetch  = 1'b1;
              flush_decode = 1'b1;
            end
            if (cnt_q == CNT_W'(1)) begin
              state_d = RUN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end

    any_ctrl = stall_fetch | stall_decode | stall_execute | stall_memory |
               bubble_execute | flush_fetch | flush_decode;
    stall_cycles_d = stall_cycles_q;
    if (any_ctrl && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign state        = state_q;
  assign stall_cycles = stall_cycles_q;

endmodule
